// File: rtl/banco_registros_p_pkg.sv
// Shared MIPS32 register-file definitions: default widths, the register-0 index
// and the byte-lane merge used by both the write path and the read bypass.
package banco_registros_p_pkg;

  localparam int S_AD_DEF   = 5;
  localparam int S_DATA_DEF = 32;
  localparam int REG_ZERO   = 0;

  // The merge works on the widest supported word; callers size-cast in and out.
  localparam int MAX_DATA  = 64;
  localparam int MAX_LANES = MAX_DATA / 8;

  function automatic logic [MAX_DATA-1:0] merge_lanes(
    input logic [MAX_DATA-1:0]  old_word,
    input logic [MAX_DATA-1:0]  new_word,
    input logic [MAX_LANES-1:0] lane_en
  );
    logic [MAX_DATA-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MAX_LANES; b++) begin
      if (lane_en[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/banco_registros_p_marcador_pend.sv
// Pending-result scoreboard: one busy bit per register plus an incrementally
// maintained count of busy registers.
module marcador_pend
  import banco_registros_p_pkg::*;
#(
  parameter int S_AD     = S_AD_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [S_AD-1:0]        mark_addr,
  input  logic                   mark_en,
  input  logic [S_AD-1:0]        clr_addr,
  input  logic                   clr_en,
  output logic [(2**S_AD)-1:0]   busy,
  output logic [S_AD:0]          num_pend
);

  localparam int DIRECCIONES = 2**S_AD;

  logic [DIRECCIONES-1:0] busy_d;
  logic [S_AD:0]          num_pend_d;
  logic                   mark_ok;
  logic                   inc;
  logic                   dec;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    mark_ok = mark_en && !((ZERO_REG != 0) && (mark_addr == S_AD'(REG_ZERO)));
    inc     = mark_ok && !busy[mark_addr];
    // A clear masked by a same-address mark leaves the bit set: no decrement.
    dec     = clr_en && busy[clr_addr] && !(mark_ok && (mark_addr == clr_addr));

    busy_d = busy;
    if (clr_en)  busy_d[clr_addr]  = 1'b0;
    if (mark_ok) busy_d[mark_addr] = 1'b1;

    num_pend_d = num_pend + (S_AD+1)'(inc) - (S_AD+1)'(dec);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      num_pend <= '0;
    end else begin
      busy     <= busy_d;
      num_pend <= num_pend_d;
    end
  end

endmodule

// File: rtl/banco_registros_p.sv
// Multi-port register file with byte-lane writes, optional write-to-read
// forwarding, hardwired register 0 and a pending-result scoreboard.
module banco_registros_p
  import banco_registros_p_pkg::*;
#(
  parameter int S_AD     = S_AD_DEF,
  parameter int S_DATA   = S_DATA_DEF,
  parameter int N_READ   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_READ*S_AD-1:0]   ARead,
  output logic [N_READ*S_DATA-1:0] DRead,
  input  logic [S_AD-1:0]          AWR,
  input  logic [S_DATA-1:0]        DataIn,
  input  logic                     WE,
  input  logic [S_DATA/8-1:0]      ByteEn,
  input  logic [S_AD-1:0]          MarkAddr,
  input  logic                     MarkEn,
  output logic [N_READ-1:0]        Busy,
  output logic [S_AD:0]            NumPend
);

  localparam int DIRECCIONES = 2**S_AD;

  logic [S_DATA-1:0]      regs_q [DIRECCIONES];
  logic [DIRECCIONES-1:0] busy_q;
  logic                   wr_ok;
  logic [S_DATA-1:0]      wr_merged;

  assign wr_ok     = WE && !((ZERO_REG != 0) && (AWR == S_AD'(REG_ZERO)));
  assign wr_merged = S_DATA'(merge_lanes(MAX_DATA'(regs_q[AWR]), MAX_DATA'(DataIn),
                                         MAX_LANES'(ByteEn)));

  // NOTE: storage is flop-based and must read as zero during reset, so every word is reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIRECCIONES; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[AWR] <= wr_merged;
    end
  end

  marcador_pend #(
    .S_AD     (S_AD),
    .ZERO_REG (ZERO_REG)
  ) u_marcador (
    .clk       (clk),
    .rst_n     (rst_n),
    .mark_addr (MarkAddr),
    .mark_en   (MarkEn),
    .clr_addr  (AWR),
    .clr_en    (WE),
    .busy      (busy_q),
    .num_pend  (NumPend)
  );

  for (genvar i = 0; i < N_READ; i++) begin : g_read
    logic [S_AD-1:0] addr;
    logic            is_zero;
    logic            fwd;
    logic            mark_hit;

    assign addr     = ARead[i*S_AD +: S_AD];
    assign is_zero  = (ZERO_REG != 0) && (addr == S_AD'(REG_ZERO));
    // Forwarding is gated by rst_n so a write held during reset never leaks out.
    assign fwd      = (BYPASS != 0) && rst_n && wr_ok && (AWR == addr);
    assign mark_hit = MarkEn && (MarkAddr == addr);

    assign DRead[i*S_DATA +: S_DATA] = is_zero ? '0 : (fwd ? wr_merged : regs_q[addr]);
    assign Busy[i] = busy_q[addr] && !(fwd && !mark_hit);
  end

endmodule

// File: tb/tb_banco_registros_p.sv
// Directed bench for banco_registros_p: expected values queued at drive time,
// popped and asserted when outputs are sampled.
module tb_banco_registros_p;

  logic        clk;
  logic        rst_n;
  logic [9:0]  ARead;
  logic [14:0] ARead3;
  logic [63:0] DRead;
  logic [63:0] dread_nb;
  logic [95:0] dread3;
  logic [4:0]  AWR;
  logic [31:0] DataIn;
  logic        WE;
  logic [3:0]  ByteEn;
  logic [4:0]  MarkAddr;
  logic        MarkEn;
  logic [1:0]  Busy;
  logic [1:0]  busy_nb;
  logic [2:0]  busy3;
  logic [5:0]  NumPend;
  logic [5:0]  num_pend_nb;
  logic [5:0]  num_pend3;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];

  banco_registros_p dut (
    .clk(clk), .rst_n(rst_n), .ARead(ARead), .DRead(DRead), .AWR(AWR),
    .DataIn(DataIn), .WE(WE), .ByteEn(ByteEn), .MarkAddr(MarkAddr),
    .MarkEn(MarkEn), .Busy(Busy), .NumPend(NumPend)
  );

  banco_registros_p #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ARead(ARead), .DRead(dread_nb), .AWR(AWR),
    .DataIn(DataIn), .WE(WE), .ByteEn(ByteEn), .MarkAddr(MarkAddr),
    .MarkEn(MarkEn), .Busy(busy_nb), .NumPend(num_pend_nb)
  );

  banco_registros_p #(.N_READ(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .ARead(ARead3), .DRead(dread3), .AWR(AWR),
    .DataIn(DataIn), .WE(WE), .ByteEn(ByteEn), .MarkAddr(MarkAddr),
    .MarkEn(MarkEn), .Busy(busy3), .NumPend(num_pend3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] observe(int sel);
    case (sel)
      0:       return DRead[31:0];
      1:       return DRead[63:32];
      2:       return 32'(NumPend);
      3:       return 32'(Busy);
      4:       return dread_nb[31:0];
      5:       return dread3[31:0];
      6:       return dread3[63:32];
      7:       return dread3[95:64];
      8:       return 32'(busy_nb);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb.push_back(it);
  endtask

  task automatic drain();
    sb_item_t    it;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.sel);
      n_assert++;
      assert (obs === it.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  initial begin
    // Reset held with a write and a mark pending: outputs must stay zero.
    rst_n    = 1'b0;
    ARead    = {5'd5, 5'd5};
    ARead3   = {3{5'd5}};
    WE       = 1'b1;
    AWR      = 5'd5;
    DataIn   = 32'hDEAD_BEEF;
    ByteEn   = 4'hF;
    MarkEn   = 1'b1;
    MarkAddr = 5'd3;
    #3;
    push("rst_dread0", 0, 32'h0);
    push("rst_dread3", 5, 32'h0);
    push("rst_busy", 3, 32'h0);
    push("rst_numpend", 2, 32'h0);
    drain();
    @(posedge clk); #1;
    push("rst_edge_dread0", 0, 32'h0);
    push("rst_edge_numpend", 2, 32'h0);
    drain();
    @(negedge clk);
    rst_n  = 1'b1;
    WE     = 1'b0;
    MarkEn = 1'b0;

    // Full-word write with bypass vs. no bypass.
    @(negedge clk);
    WE = 1'b1; AWR = 5'd5; DataIn = 32'hDEAD_BEEF; ByteEn = 4'hF;
    ARead = {5'd5, 5'd5};
    #1;
    push("byp_dread0", 0, 32'hDEAD_BEEF);
    push("byp_dread1", 1, 32'hDEAD_BEEF);
    push("nobyp_dread0", 4, 32'h0);
    drain();
    @(posedge clk); #1;
    WE = 1'b0;
    push("wr5_dread0", 0, 32'hDEAD_BEEF);
    push("wr5_nobyp", 4, 32'hDEAD_BEEF);
    drain();

    // Byte-lane merge.
    @(negedge clk);
    WE = 1'b1; AWR = 5'd7; DataIn = 32'h1122_3344; ByteEn = 4'hF;
    ARead = {5'd0, 5'd7};
    @(negedge clk);
    DataIn = 32'hAABB_CCDD; ByteEn = 4'b0101;
    #1;
    push("lane_byp", 0, 32'h11BB_33DD);
    push("lane_nobyp", 4, 32'h1122_3344);
    drain();
    @(posedge clk); #1;
    WE = 1'b0;
    push("lane_stored", 0, 32'h11BB_33DD);
    push("lane_stored_nb", 4, 32'h11BB_33DD);
    drain();

    // Register 0 is hardwired.
    @(negedge clk);
    WE = 1'b1; AWR = 5'd0; DataIn = 32'hFFFF_FFFF; ByteEn = 4'hF;
    ARead = {5'd0, 5'd0};
    #1;
    push("r0_byp_p0", 0, 32'h0);
    push("r0_byp_p1", 1, 32'h0);
    drain();
    @(posedge clk); #1;
    WE = 1'b0;
    push("r0_p0", 0, 32'h0);
    push("r0_p1", 1, 32'h0);
    drain();
    @(negedge clk);
    MarkEn = 1'b1; MarkAddr = 5'd0;
    @(posedge clk); #1;
    MarkEn = 1'b0;
    push("r0_mark_numpend", 2, 32'h0);
    push("r0_mark_busy", 3, 32'h0);
    drain();

    // Scoreboard marks and clears.
    @(negedge clk);
    MarkEn = 1'b1; MarkAddr = 5'd3;
    @(negedge clk);
    MarkAddr = 5'd9;
    @(negedge clk);
    MarkEn = 1'b0;
    ARead = {5'd9, 5'd3};
    #1;
    push("mark_numpend", 2, 32'd2);
    push("mark_busy", 3, 32'b11);
    drain();
    @(negedge clk);
    WE = 1'b1; AWR = 5'd3; DataIn = 32'h1; ByteEn = 4'hF;
    MarkEn = 1'b1; MarkAddr = 5'd3;
    #1;
    push("markwin_busy_comb", 3, 32'b11);
    drain();
    @(posedge clk); #1;
    WE = 1'b0; MarkEn = 1'b0;
    push("markwin_numpend", 2, 32'd2);
    push("markwin_busy", 3, 32'b11);
    drain();
    @(negedge clk);
    WE = 1'b1; AWR = 5'd9; DataIn = 32'h0; ByteEn = 4'h0;
    #1;
    push("clr9_busy_byp", 3, 32'b01);
    push("clr9_busy_nobyp", 8, 32'b11);
    drain();
    @(posedge clk); #1;
    WE = 1'b0;
    push("clr9_numpend", 2, 32'd1);
    push("clr9_busy", 3, 32'b01);
    push("clr9_data", 1, 32'h0);
    drain();
    @(negedge clk);
    WE = 1'b1; AWR = 5'd3; DataIn = 32'h33; ByteEn = 4'hF;
    MarkEn = 1'b1; MarkAddr = 5'd4;
    @(posedge clk); #1;
    WE = 1'b0; MarkEn = 1'b0;
    push("swap_numpend", 2, 32'd1);
    drain();

    // Mark every nonzero register (4 is already busy), then reset mid-cycle.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      MarkEn = 1'b1; MarkAddr = 5'(a);
    end
    @(negedge clk);
    MarkEn = 1'b0;
    #1;
    push("all_numpend", 2, 32'd31);
    drain();
    ARead = {5'd7, 5'd5};
    WE = 1'b1; AWR = 5'd5; DataIn = 32'h1234_5678; ByteEn = 4'hF;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    push("midrst_dread0", 0, 32'h0);
    push("midrst_dread1", 1, 32'h0);
    push("midrst_busy", 3, 32'h0);
    push("midrst_numpend", 2, 32'h0);
    drain();
    #1;
    WE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    push("postrst_dread0", 0, 32'h0);
    drain();

    // Three read ports all forwarding the same merged write.
    @(negedge clk);
    WE = 1'b1; AWR = 5'd12; DataIn = 32'hCAFE_F00D; ByteEn = 4'hF;
    @(negedge clk);
    DataIn = 32'h1234_5678; ByteEn = 4'b0011;
    ARead3 = {3{5'd12}};
    #1;
    push("n3_port0", 5, 32'hCAFE_5678);
    push("n3_port1", 6, 32'hCAFE_5678);
    push("n3_port2", 7, 32'hCAFE_5678);
    drain();
    @(posedge clk); #1;
    WE = 1'b0;
    push("n3_stored", 5, 32'hCAFE_5678);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/banco_registros_p.md
BANCO_REGISTROS_P -- requirements
Module: banco_registros_p

Interface
REQ-001 SHALL have parameter S_AD, default 5, address width; depth is DIRECCIONES = 2**S_AD.
REQ-002 SHALL have parameter S_DATA, default 32, data width, a multiple of 8.
REQ-003 SHALL have parameter N_READ, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-005 SHALL have parameter ZERO_REG, default 1; 1 means register 0 is hardwired to zero.
REQ-006 SHALL use one clock and an asynchronous, active-low reset, as decided.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port ARead, input, N_READ*S_AD bits: read addresses; port i occupies slice [i*S_AD +: S_AD].
REQ-010 SHALL have port DRead, output, N_READ*S_DATA bits: read data, sliced the same way.
REQ-011 SHALL have port AWR, input, S_AD bits: write address.
REQ-012 SHALL have port DataIn, input, S_DATA bits: write data.
REQ-013 SHALL have port WE, input, 1 bit: write enable.
REQ-014 SHALL have port ByteEn, input, S_DATA/8 bits: per-byte write lane enables.
REQ-015 SHALL have port MarkAddr, input, S_AD bits: destination of an issued, not-yet-written result.
REQ-016 SHALL have port MarkEn, input, 1 bit: sets the busy flag of MarkAddr.
REQ-017 SHALL have port Busy, output, N_READ bits: pending flag of each read port's address.
REQ-018 SHALL have port NumPend, output, S_AD+1 bits: registered count of busy registers.

Function
REQ-019 SHALL commit the write at the rising clk edge when WE=1; only bytes whose ByteEn bit is 1 change; writes to address 0 are dropped when ZERO_REG=1.
REQ-020 SHALL make reads combinational, with zero-cycle latency from ARead to DRead.
REQ-021 SHALL return 0 on DRead for address 0 when ZERO_REG=1, regardless of prior writes.
REQ-022 SHALL, when BYPASS=1, WE=1 and a nonzero AWR (or any AWR when ZERO_REG=0) equals a read address, drive that DRead as the post-write merged word: enabled lanes from DataIn, other lanes from storage. When BYPASS=0, the stored value is returned and the new data appears on the next cycle.
REQ-023 SHALL hold a scoreboard with one busy bit per register.
REQ-024 SHALL set busy[MarkAddr] at the clock edge when MarkEn=1, and clear busy[AWR] when WE=1. Writes with all ByteEn bits zero still clear the bit.
REQ-025 SHALL let the mark win when MarkEn and WE target the same address in the same cycle, so the bit ends at 1.
REQ-026 SHALL never set a busy bit for address 0 when ZERO_REG=1; Busy for address 0 is always 0.
REQ-027 SHALL drive Busy[i] combinationally as busy[ARead_i]. When BYPASS=1 and a same-cycle write clears that address without a same-address mark, Busy[i]=0.
REQ-028 SHALL update NumPend incrementally each edge: +1 per 0->1 transition, -1 per 1->0 transition, net 0 for mark plus clear on the same already-busy address. NumPend SHALL always equal the popcount of the busy bits and never wrap; its maximum is DIRECCIONES-1 with ZERO_REG=1, else DIRECCIONES.
REQ-029 SHALL treat re-marking an already-busy register as a no-op on NumPend.

Reset
REQ-030 SHALL, on rst_n low, immediately and asynchronously clear all registers to 0, all busy bits to 0 and NumPend to 0, independent of clk.
REQ-031 SHALL make DRead 0 for every address and Busy all 0 while rst_n is low.
REQ-032 SHALL accept writes and marks from the first rising clk edge after rst_n deasserts.
REQ-033 SHALL discard any write or mark coincident with reset; no partial update.

Structure
REQ-034 SHALL place S_AD/S_DATA defaults, the register-0 index constant and the ByteEn lane-merge function in the shared MIPS32 package.
REQ-035 SHALL use one sub-module, marcador_pend (busy bits plus NumPend counter); storage, ports and bypass stay in banco_registros_p.

Verification
REQ-036 SHALL cover: reset, then WE=1, AWR=5, DataIn=0xDEADBEEF, ByteEn=1111 -> next cycle ARead0=5 reads 0xDEADBEEF. In the write cycle, DRead0 shows 0xDEADBEEF with BYPASS=1 and 0x00000000 with BYPASS=0.
REQ-037 SHALL cover: reg 7=0x11223344, then WE with ByteEn=0101, DataIn=0xAABBCCDD -> reg 7=0x11BB33DD.
REQ-038 SHALL cover: WE=1, AWR=0, DataIn=0xFFFFFFFF with ZERO_REG=1 -> DRead=0 on both ports; MarkEn with MarkAddr=0 -> NumPend stays 0.
REQ-039 SHALL cover: MarkEn on 3 then 9 -> NumPend=2 and Busy=1 for reads of 3/9; WE to 3 plus MarkEn to 3 in the same cycle -> busy[3] stays 1, NumPend=2; WE to 9 -> NumPend=1.
REQ-040 SHALL cover: mark all 31 nonzero registers -> NumPend=31; assert rst_n low mid-cycle -> all outputs 0 before the next clk edge.
REQ-041 SHALL cover: N_READ=3 build with all ports reading AWR during a bypass write -> all three DRead slices show the merged value.
